mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbiter and sequencer for the single-ported unified instruction/data memory. It shares the port between the fetch stage (single-word instruction reads) and the memory stage (LDD/STD, plus PUSH/POP/CALL/RET/RTI/interrupt stack traffic as 1–4 beat bursts). The data side has priority. A data burst holds the port for all of its beats. Each finished burst gives fetch one guaranteed slot.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 8, memory word width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; one clock, sampled on rising edge
- if_req  in  1  fetch wants a word (level)
- if_addr  in  ADDR_W  fetch address, valid with if_req
- if_gnt  out  1  fetch read issued to memory this cycle
- if_rvalid  out  1  if_rdata valid (cycle after if_gnt)
- if_rdata  out  DATA_W  fetched word
- fetch_stall  out  1  if_req && !if_gnt (combinational)
- dm_req  in  1  data access request; held high until dm_done
- dm_we  in  1  1 = write burst, 0 = read burst
- dm_addr  in  ADDR_W  base address of beat 0
- dm_len  in  2  beats minus 1 (0..3)
- dm_dir  in  1  0 = address increments per beat, 1 = decrements
- dm_wdata  in  DATA_W  write data for the current beat; passed through while dm_beat=1
- dm_gnt  out  1  beat 0 issued; dm_we, dm_addr, dm_len, dm_dir captured
- dm_beat  out  1  a data beat is issued to memory this cycle
- dm_rvalid  out  1  dm_rdata valid for the read beat issued in the previous cycle
- dm_rdata  out  DATA_W  read word
- dm_done  out  1  one-cycle pulse: burst complete
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  synchronous read data, valid the cycle after mem_en && !mem_we

## Operation
- FSM states: IDLE, DM_BURST, DM_TAIL. Registered state holds: captured we/len/dir/base, a 2-bit beat counter, a 1-bit blank flag and a 2-bit read-return tag (none/fetch/data).
- **IDLE**
  - If dm_req && !blank: issue beat 0 at dm_addr and pulse dm_gnt and dm_beat. Go to DM_BURST if dm_len>0, else to DM_TAIL.
  - Else if if_req: issue a fetch read at if_addr and pulse if_gnt. Stay in IDLE.
  - Else mem_en=0.
  - blank clears after one IDLE cycle.
- **DM_BURST**
  - Issue beat k (k = 1..len) at base + k (dir=0) or base − k (dir=1), modulo 2^ADDR_W.
  - mem_we=captured we; mem_wdata=dm_wdata.
  - After beat len, go to DM_TAIL.
  - if_req is not granted in this state.
- **DM_TAIL**
  - dm_done=1. For reads, the last dm_rvalid occurs in this cycle.
  - The port is free: a pending if_req is granted here (if_gnt=1).
  - Set blank; go to IDLE.
- blank makes the first IDLE cycle after dm_done ignore dm_req, which gives the requester a cycle to drop it. A dm_req still high after that is a new burst.
- Read routing: the tag registered at issue steers the next cycle's mem_rdata to if_rdata/if_rvalid or to dm_rdata/dm_rvalid. Write beats set no tag.
- dm_len, dm_dir, dm_we and dm_addr changes after dm_gnt are ignored until the next grant.
- Reset (any state, including mid-burst):
  - state=IDLE, counter=0, blank=0, tag=none.
  - All registered outputs are 0.
  - A read issued in the cycle before reset produces no rvalid.
  - Combinational outputs depend on state only; during reset cycles they are forced to 0.

## Timing
- Fetch: if_gnt at T → if_rvalid/if_rdata at T+1. Back-to-back fetches sustain 1 word/cycle.
- Data burst with L = dm_len, dm_gnt at T:
  - dm_beat at T..T+L.
  - Read data (dm_rvalid) at T+1..T+L+1.
  - dm_done at T+L+1.
  - Earliest fetch grant is T+L+1.
  - Earliest new data grant is T+L+3.
- Simultaneous dm_req and if_req in IDLE: data wins; fetch_stall=1 until granted.
- A data request arriving while a fetch read is returning is granted the same cycle. The fetch return and the new issue coexist, with no bubble.

## Test plan
- Reset with if_req=1, if_addr=0x00 held → mem_en, if_gnt, dm_* outputs = 0 during reset. First if_gnt is on the cycle after reset deasserts; if_rvalid follows one cycle later.
- Continuous if_req, if_addr 0x10,0x11,0x12 (mem = 0xA1,0xA2,0xA3) → if_gnt every cycle; if_rdata 0xA1,0xA2,0xA3 on consecutive cycles; fetch_stall=0.
- Same-cycle if_req (0x20) and dm_req read len=0 addr 0x40 (mem=0x5C) at T:
  - dm_gnt at T, fetch_stall=1 at T.
  - dm_rvalid/dm_rdata=0x5C and dm_done at T+1.
  - if_gnt at T+1, if_rvalid at T+2.
- RTI-style pop, dm_len=1, dir=0, addr 0xFF → beats at 0xFF then 0x00 (wrap); dm_rvalid at T+1 and T+2; dm_done at T+2.
- Push burst, dm_we=1, len=1, dir=1, addr 0x05, wdata 0xAA then 0xBB:
  - Expect mem[0x05]=0xAA, mem[0x04]=0xBB, dm_done at T+2.
  - dm_req left high through T+3 is ignored at T+3 and re-granted at T+4.
- Reset asserted at T+1 of a len=3 read burst → no further dm_beat, dm_rvalid or dm_done. The FSM is in IDLE, and the next dm_req is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the memory port arbiter, its two requesters and the memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);

  // Fetch side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              fetch_stall;

  // Data (memory stage) side
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [1:0]        dm_len;
  logic              dm_dir;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt;
  logic              dm_beat;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;

  // Memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side of the bundle
  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, fetch_stall,
    input  dm_req, dm_we, dm_addr, dm_len, dm_dir, dm_wdata,
    output dm_gnt, dm_beat, dm_rvalid, dm_rdata, dm_done,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  // Requester / memory side of the bundle
  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, fetch_stall,
    output dm_req, dm_we, dm_addr, dm_len, dm_dir, dm_wdata,
    input  dm_gnt, dm_beat, dm_rvalid, dm_rdata, dm_done,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the single-ported unified instruction/data memory.
// Data bursts (1-4 beats) have priority and hold the port; every finished
// burst leaves a free slot for fetch, then one blank cycle in which dm_req
// is ignored so the requester can drop it.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DM_BURST = 2'd1,
    DM_TAIL  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    TAG_NONE  = 2'd0,
    TAG_FETCH = 2'd1,
    TAG_DATA  = 2'd2
  } tag_e;

  state_e            state_q, state_d;
  tag_e              tag_q, tag_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              blank_q, blank_d;
  logic              cap_we_q, cap_we_d;
  logic              cap_dir_q, cap_dir_d;
  logic [1:0]        cap_len_q, cap_len_d;
  logic [ADDR_W-1:0] cap_base_q, cap_base_d;

  logic              if_gnt_c;
  logic              dm_gnt_c;
  logic              dm_beat_c;
  logic              dm_done_c;
  logic              mem_en_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [ADDR_W-1:0] beat_addr_c;
  logic              if_rvalid_c;
  logic              dm_rvalid_c;

  // Address of burst beat k relative to the captured base, wrapping mod 2^ADDR_W
  assign beat_addr_c = cap_dir_q ? (cap_base_q - ADDR_W'(cnt_q))
                                 : (cap_base_q + ADDR_W'(cnt_q));

  // State and sequencing registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tag_q      <= TAG_NONE;
      cnt_q      <= 2'd0;
      blank_q    <= 1'b0;
      cap_we_q   <= 1'b0;
      cap_dir_q  <= 1'b0;
      cap_len_q  <= 2'd0;
      cap_base_q <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      cnt_q      <= cnt_d;
      blank_q    <= blank_d;
      cap_we_q   <= cap_we_d;
      cap_dir_q  <= cap_dir_d;
      cap_len_q  <= cap_len_d;
      cap_base_q <= cap_base_d;
    end
  end

  // Next-state, port arbitration and memory-port drive
  always_comb begin
    state_d     = state_q;
    tag_d       = TAG_NONE;
    cnt_d       = cnt_q;
    blank_d     = blank_q;
    cap_we_d    = cap_we_q;
    cap_dir_d   = cap_dir_q;
    cap_len_d   = cap_len_q;
    cap_base_d  = cap_base_q;
    if_gnt_c    = 1'b0;
    dm_gnt_c    = 1'b0;
    dm_beat_c   = 1'b0;
    dm_done_c   = 1'b0;
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;

    unique case (state_q)
      IDLE: begin
        blank_d = 1'b0;
        if (bus.dm_req && !blank_q) begin
          dm_gnt_c    = 1'b1;
          dm_beat_c   = 1'b1;
          mem_en_c    = 1'b1;
          mem_we_c    = bus.dm_we;
          mem_addr_c  = bus.dm_addr;
          mem_wdata_c = bus.dm_wdata;
          cap_we_d    = bus.dm_we;
          cap_dir_d   = bus.dm_dir;
          cap_len_d   = bus.dm_len;
          cap_base_d  = bus.dm_addr;
          cnt_d       = 2'd1;
          tag_d       = bus.dm_we ? TAG_NONE : TAG_DATA;
          state_d     = (bus.dm_len != 2'd0) ? DM_BURST : DM_TAIL;
        end else if (bus.if_req) begin
          if_gnt_c   = 1'b1;
          mem_en_c   = 1'b1;
          mem_addr_c = bus.if_addr;
          tag_d      = TAG_FETCH;
        end
      end

      DM_BURST: begin
        dm_beat_c   = 1'b1;
        mem_en_c    = 1'b1;
        mem_we_c    = cap_we_q;
        mem_addr_c  = beat_addr_c;
        mem_wdata_c = bus.dm_wdata;
        tag_d       = cap_we_q ? TAG_NONE : TAG_DATA;
        if (cnt_q == cap_len_q) begin
          state_d = DM_TAIL;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      DM_TAIL: begin
        dm_done_c = 1'b1;
        blank_d   = 1'b1;
        cnt_d     = 2'd0;
        state_d   = IDLE;
        if (bus.if_req) begin
          if_gnt_c   = 1'b1;
          mem_en_c   = 1'b1;
          mem_addr_c = bus.if_addr;
          tag_d      = TAG_FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Nothing leaves the block while reset is held
    if (reset) begin
      if_gnt_c    = 1'b0;
      dm_gnt_c    = 1'b0;
      dm_beat_c   = 1'b0;
      dm_done_c   = 1'b0;
      mem_en_c    = 1'b0;
      mem_we_c    = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
    end
  end

  // Read return steered by the tag registered at issue; a read in flight across reset is dropped
  assign if_rvalid_c = !reset && (tag_q == TAG_FETCH);
  assign dm_rvalid_c = !reset && (tag_q == TAG_DATA);

  // Drive the bus
  assign bus.if_gnt      = if_gnt_c;
  assign bus.if_rvalid   = if_rvalid_c;
  assign bus.if_rdata    = if_rvalid_c ? bus.mem_rdata : '0;
  assign bus.fetch_stall = !reset && bus.if_req && !if_gnt_c;
  assign bus.dm_gnt      = dm_gnt_c;
  assign bus.dm_beat     = dm_beat_c;
  assign bus.dm_rvalid   = dm_rvalid_c;
  assign bus.dm_rdata    = dm_rvalid_c ? bus.mem_rdata : '0;
  assign bus.dm_done     = dm_done_c;
  assign bus.mem_en      = mem_en_c;
  assign bus.mem_we      = mem_we_c;
  assign bus.mem_addr    = mem_addr_c;
  assign bus.mem_wdata   = mem_wdata_c;

  // The port carries at most one requester per cycle
  a_port_exclusive: assert property (@(posedge clk) disable iff (reset)
    !(if_gnt_c && dm_beat_c));

  // dm_done is a single-cycle pulse
  a_done_pulse: assert property (@(posedge clk) disable iff (reset)
    dm_done_c |=> !dm_done_c);

  // Fetch is never granted in the middle of a burst
  a_no_fetch_in_burst: assert property (@(posedge clk) disable iff (reset)
    (state_q == DM_BURST) |-> !if_gnt_c);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Cycle-by-cycle vector bench for mem_port_arbiter with a read-data scoreboard.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b ();

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  // Synchronous single-port memory
  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (b.mem_en) begin
      if (b.mem_we) mem[b.mem_addr] <= b.mem_wdata;
      else          b.mem_rdata     <= mem[b.mem_addr];
    end
  end

  // One row = inputs for one cycle and the outputs expected in that cycle.
  // flags = {if_gnt, if_rvalid, fetch_stall, dm_gnt, dm_beat, dm_rvalid, dm_done, mem_en, mem_we}
  typedef struct {
    logic       rst;
    logic       ifr;
    logic [7:0] ifa;
    logic       dr;
    logic       dwe;
    logic [7:0] da;
    logic [1:0] dl;
    logic       dd;
    logic [7:0] dw;
    logic [8:0] flags;
    logic [7:0] maddr;
    logic       push_if;
    logic [7:0] exp_if;
    logic       push_dm;
    logic [7:0] exp_dm;
  } vec_t;

  vec_t       vecs [$];
  logic [7:0] q_if [$];
  logic [7:0] q_dm [$];
  int         checks = 0;
  int         passes = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic add(input logic rst, input logic ifr, input logic [7:0] ifa,
                     input logic dr, input logic dwe, input logic [7:0] da,
                     input logic [1:0] dl, input logic dd, input logic [7:0] dw,
                     input logic [8:0] flags, input logic [7:0] maddr,
                     input logic pi, input logic [7:0] ei,
                     input logic pd, input logic [7:0] ed);
    vec_t v;
    v.rst = rst; v.ifr = ifr; v.ifa = ifa; v.dr = dr; v.dwe = dwe; v.da = da;
    v.dl = dl; v.dd = dd; v.dw = dw; v.flags = flags; v.maddr = maddr;
    v.push_if = pi; v.exp_if = ei; v.push_dm = pd; v.exp_dm = ed;
    vecs.push_back(v);
  endtask

  // Scoreboard: every rvalid pops the oldest expected word of its side
  always @(negedge clk) begin
    if (b.if_rvalid) begin
      if (q_if.size() == 0) check("if_rvalid_unexpected", 32'(b.if_rdata), 32'hFFFF_FFFF);
      else                  check("if_rdata", 32'(b.if_rdata), 32'(q_if.pop_front()));
    end
    if (b.dm_rvalid) begin
      if (q_dm.size() == 0) check("dm_rvalid_unexpected", 32'(b.dm_rdata), 32'hFFFF_FFFF);
      else                  check("dm_rdata", 32'(b.dm_rdata), 32'(q_dm.pop_front()));
    end
  end

  initial begin
    logic [8:0] act_flags;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h55;
    mem[8'h00] = 8'h88; mem[8'h10] = 8'hA1; mem[8'h11] = 8'hA2; mem[8'h12] = 8'hA3;
    mem[8'h20] = 8'h3C; mem[8'h40] = 8'h5C; mem[8'hFF] = 8'h77; mem[8'h80] = 8'h90;
    b.mem_rdata = 8'h00;

    //   rst ifr ifa    dr dwe da     dl    dd  dw     flags          maddr  pi ei     pd ed
    // reset with fetch requesting, then first grant right after reset
    add(1, 1, 8'h00, 0, 0, 8'h00, 2'd0, 0, 8'h00, 9'b000_0000_00, 8'h00, 0, 8'h00, 0, 8'h00);
    add(1, 1, 8'h00, 0, 0, 8'h00, 2'd0, 0, 8'h00, 9'b000_0000_00, 8'h00, 0, 8'h00, 0, 8'h00);
    add(0, 1, 8'h00, 0, 0, 8'h00, 2'd0, 0, 8'h00, 9'b100_0000_10, 8'h00, 1, 8'h88, 0, 8'h00);
    // back-to-back fetch stream
    add(0, 1, 8'h10, 0, 0, 8'h00, 2'd0, 0, 8'h00, 9'b110_0000_10, 8'h10, 1, 8'hA1, 0, 8'h00);
    add(0, 1, 8'h11, 0, 0, 8'h00, 2'd0, 0, 8'h00, 9'b110_0000_10, 8'h11, 1, 8'hA2, 0, 8'h00);
    add(0, 1, 8'h12, 0, 0, 8'h00, 2'd0, 0, 8'h00, 9'b110_0000_10, 8'h12, 1, 8'hA3, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 8'h00, 9'b010_0000_00, 8'h00, 0, 8'h00, 0, 8'h00);
    // same-cycle fetch and len=0 data read: data wins, fetch takes the tail slot
    add(0, 1, 8'h20, 1, 0, 8'h40, 2'd0, 0, 8'h00, 9'b001_1100_10, 8'h40, 0, 8'h00, 1, 8'h5C);
    add(0, 1, 8'h20, 1, 0, 8'h40, 2'd0, 0, 8'h00, 9'b100_0011_10, 8'h20, 1, 8'h3C, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 8'h00, 9'b010_0000_00, 8'h00, 0, 8'h00, 0, 8'h00);
    // pop len=1 upward from 0xFF wraps to 0x00; post-grant input changes ignored
    add(0, 0, 8'h00, 1, 0, 8'hFF, 2'd1, 0, 8'h00, 9'b000_1100_10, 8'hFF, 0, 8'h00, 1, 8'h77);
    add(0, 0, 8'h00, 1, 0, 8'h33, 2'd3, 1, 8'h00, 9'b000_0110_10, 8'h00, 0, 8'h00, 1, 8'h88);
    add(0, 0, 8'h00, 1, 0, 8'h33, 2'd3, 1, 8'h00, 9'b000_0011_00, 8'h00, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 8'h00, 9'b000_0000_00, 8'h00, 0, 8'h00, 0, 8'h00);
    // push len=1 downward from 0x05; dm_req held into the blank cycle is ignored
    add(0, 0, 8'h00, 1, 1, 8'h05, 2'd1, 1, 8'hAA, 9'b000_1100_11, 8'h05, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 1, 1, 8'h60, 2'd0, 0, 8'hBB, 9'b000_0100_11, 8'h04, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 1, 1, 8'h05, 2'd1, 1, 8'h00, 9'b000_0001_00, 8'h00, 0, 8'h00, 0, 8'h00);
    add(0, 1, 8'h11, 1, 1, 8'h05, 2'd1, 1, 8'h00, 9'b100_0000_10, 8'h11, 1, 8'hA2, 0, 8'h00);
    // new data grant while the fetch word returns; reads back the pushed word
    add(0, 1, 8'h12, 1, 0, 8'h04, 2'd0, 0, 8'h00, 9'b011_1100_10, 8'h04, 0, 8'h00, 1, 8'hBB);
    add(0, 1, 8'h12, 1, 0, 8'h04, 2'd0, 0, 8'h00, 9'b100_0011_10, 8'h12, 1, 8'hA3, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 8'h00, 9'b010_0000_00, 8'h00, 0, 8'h00, 0, 8'h00);
    // reset at T+1 of a len=3 read burst, then a normal grant
    add(0, 0, 8'h00, 1, 0, 8'h80, 2'd3, 0, 8'h00, 9'b000_1100_10, 8'h80, 0, 8'h00, 0, 8'h00);
    add(1, 0, 8'h00, 1, 0, 8'h80, 2'd3, 0, 8'h00, 9'b000_0000_00, 8'h00, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 1, 0, 8'h80, 2'd0, 0, 8'h00, 9'b000_1100_10, 8'h80, 0, 8'h00, 1, 8'h90);
    add(0, 0, 8'h00, 1, 0, 8'h80, 2'd0, 0, 8'h00, 9'b000_0011_00, 8'h00, 0, 8'h00, 0, 8'h00);
    add(0, 0, 8'h00, 0, 0, 8'h00, 2'd0, 0, 8'h00, 9'b000_0000_00, 8'h00, 0, 8'h00, 0, 8'h00);

    foreach (vecs[i]) begin
      reset      = vecs[i].rst;
      b.if_req   = vecs[i].ifr;
      b.if_addr  = vecs[i].ifa;
      b.dm_req   = vecs[i].dr;
      b.dm_we    = vecs[i].dwe;
      b.dm_addr  = vecs[i].da;
      b.dm_len   = vecs[i].dl;
      b.dm_dir   = vecs[i].dd;
      b.dm_wdata = vecs[i].dw;
      if (vecs[i].push_if) q_if.push_back(vecs[i].exp_if);
      if (vecs[i].push_dm) q_dm.push_back(vecs[i].exp_dm);
      @(negedge clk);
      act_flags = {b.if_gnt, b.if_rvalid, b.fetch_stall, b.dm_gnt, b.dm_beat,
                   b.dm_rvalid, b.dm_done, b.mem_en, b.mem_we};
      check($sformatf("row%0d_flags", i), 32'(act_flags), 32'(vecs[i].flags));
      if (vecs[i].flags[1]) check($sformatf("row%0d_mem_addr", i), 32'(b.mem_addr), 32'(vecs[i].maddr));
      @(posedge clk);
      #1;
    end

    // Push burst left its two words in memory
    check("mem_05_after_push", 32'(mem[8'h05]), 32'hAA);
    check("mem_04_after_push", 32'(mem[8'h04]), 32'hBB);
    // Every expected read word was returned
    check("if_queue_drained", 32'(q_if.size()), 32'd0);
    check("dm_queue_drained", 32'(q_dm.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
